aes_cbc_ctrl: RTL and testbench

CBC-mode front end that sits directly upstream of the AES-128 iterative encryption core. It accepts plaintext blocks on a valid/ready stream and XORs each block with the chaining value (IV or the previous ciphertext). It then launches the core with a start pulse, waits for the core's done pulse, and presents the ciphertext on a valid/ready output stream. One block is in flight at a time, and the chaining value updates from the core output.

---
 rtl/aes_pkg.sv | 12 +
 rtl/aes_cbc_ctrl.sv | 130 +++++++++++++
 tb/tb_aes_cbc_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, FSM encoding and defaults for the AES CBC front end.
package aes_pkg;
    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W = 128;
    localparam int TIMEOUT_CYCLES_DEF = 64;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;
endpackage

// File: rtl/aes_cbc_ctrl.sv
// aes_cbc_ctrl: CBC chaining front end that feeds one block at a time to an iterative AES-128 core.
module aes_cbc_ctrl
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iv_load,
    input  logic [AES_BLOCK_W-1:0] iv_in,
    input  logic [AES_KEY_W-1:0]   key_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   out_last,
    output logic                   core_start,
    output logic [AES_BLOCK_W-1:0] core_plaintext,
    output logic [AES_KEY_W-1:0]   core_key,
    input  logic                   core_done,
    input  logic [AES_BLOCK_W-1:0] core_ciphertext,
    output logic [CNT_W-1:0]       blk_count,
    output logic                   err_timeout
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t state_q, state_d;
    logic [AES_BLOCK_W-1:0] iv_q, iv_d, chain_q, chain_d, pt_q, pt_d, out_data_q, out_data_d, chain_sel;
    logic [AES_KEY_W-1:0] key_q, key_d;
    logic last_q, last_d, out_last_q, out_last_d, err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic accept, expire;

    assign accept = in_valid && in_ready;
    assign expire = state_q == S_WAIT && !core_done && timer_q == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = accept ? S_ISSUE : S_IDLE;
            S_ISSUE:  state_d = S_WAIT;
            S_WAIT:   state_d = core_done ? S_OUTPUT : (expire ? S_IDLE : S_WAIT);
            S_OUTPUT: state_d = out_ready ? S_IDLE : S_OUTPUT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Reset parks the FSM in IDLE, so in_ready must also be gated by rst itself.
    always_comb begin
        in_ready = state_q == S_IDLE && !rst;
        core_start = state_q == S_ISSUE;
        out_valid = state_q == S_OUTPUT;
    end

    always_comb begin
        chain_sel = iv_load ? iv_in : chain_q;
        iv_d = iv_load ? iv_in : iv_q;
        chain_d = (iv_load && state_q == S_IDLE) ? iv_in : chain_q;
        pt_d = pt_q;
        key_d = key_q;
        last_d = last_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        err_d = err_q;
        cnt_d = cnt_q;
        timer_d = timer_q;
        if (accept) begin
            pt_d = in_data ^ chain_sel;
            key_d = key_in;
            last_d = in_last;
        end
        if (state_q == S_ISSUE) timer_d = '0;
        if (state_q == S_WAIT) begin
            timer_d = timer_q + 1'b1;
            if (core_done) begin
                out_data_d = core_ciphertext;
                out_last_d = last_q;
                chain_d = last_q ? iv_q : core_ciphertext;
                cnt_d = last_q ? '0 : cnt_q + 1'b1;
            end else if (expire) begin
                err_d = 1'b1;
                chain_d = iv_q;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iv_q <= '0;
            chain_q <= '0;
            pt_q <= '0;
            key_q <= '0;
            last_q <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
            timer_q <= '0;
        end else begin
            iv_q <= iv_d;
            chain_q <= chain_d;
            pt_q <= pt_d;
            key_q <= key_d;
            last_q <= last_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
            timer_q <= timer_d;
        end
    end

    assign out_data = out_data_q;
    assign out_last = out_last_q;
    assign core_plaintext = pt_q;
    assign core_key = key_q;
    assign blk_count = cnt_q;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// tb_aes_cbc_ctrl: randomized and directed checks of the CBC front end against a block-level CBC model.
module tb_aes_cbc_ctrl;
    logic clk = 0, rst = 1, iv_load = 0, in_valid = 0, in_last = 0, out_ready = 0, core_done = 0;
    logic [127:0] iv_in = '0, key_in = '0, in_data = '0, core_ciphertext = '0;
    logic in_ready, out_valid, out_last, core_start, err_timeout;
    logic [127:0] out_data, core_plaintext, core_key;
    logic [15:0] blk_count;

    int pass_cnt = 0, total = 0;
    logic [127:0] m_iv = '0, m_chain = '0, last_out;
    logic [15:0] m_cnt = '0;

    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;

    aes_cbc_ctrl dut (
        .clk(clk), .rst(rst), .iv_load(iv_load), .iv_in(iv_in), .key_in(key_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .core_start(core_start), .core_plaintext(core_plaintext), .core_key(core_key),
        .core_done(core_done), .core_ciphertext(core_ciphertext),
        .blk_count(blk_count), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Core stand-in: real AES results for the known vectors, a keyed mix otherwise.
    function automatic logic [127:0] core_model(input logic [127:0] b, input logic [127:0] k);
        if (k == 128'h000102030405060708090a0b0c0d0e0f && b == 128'h00112233445566778899aabbccddeeff)
            return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        if (k == K2 && b == 128'h6bc0bce12a459991e134741a7f9e1925) return CT1;
        if (k == K2 && b == 128'hd86421fb9f1a1eda505ee1375746972c) return CT2;
        return {b[94:0], b[127:95]} ^ k ^ 128'h5a5a_3c3c_0f0f_9696_a5a5_c3c3_f0f0_6969;
    endfunction

    int core_lat = 2;
    logic stub_en = 1, stub_busy = 0;
    int stub_cnt = 0;
    logic [127:0] stub_res = '0;
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_start === 1'b1) begin
            stub_busy <= 1'b1;
            stub_cnt <= core_lat;
            stub_res <= core_model(core_plaintext, core_key);
        end else if (stub_busy) begin
            if (stub_cnt <= 1) begin
                stub_busy <= 1'b0;
                core_done <= stub_en;
                core_ciphertext <= stub_res;
            end else stub_cnt <= stub_cnt - 1;
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [127:0] pt, input logic [127:0] k, input logic last, input logic ld,
                        input logic [127:0] niv, input logic mid, input logic [127:0] miv,
                        input int hold, input int lat);
        logic [127:0] exp, held;
        logic [15:0] exp_cnt;
        int starts, bad_rdy, n, bad_hold;
        core_lat = lat;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL send_ready: in_ready=%b want 1", in_ready);
        else pass_cnt++;
        if (ld) begin m_iv = niv; m_chain = niv; end
        exp = core_model(pt ^ m_chain, k);
        exp_cnt = last ? 16'd0 : m_cnt + 16'd1;
        in_valid = 1; in_data = pt; key_in = k; in_last = last; iv_load = ld; iv_in = niv;
        @(posedge clk); #1;
        in_valid = 0; iv_load = 0;
        starts = 0; bad_rdy = 0; n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (core_start === 1'b1) starts++;
            if (in_ready !== 1'b0) bad_rdy++;
            if (mid && n == 1) begin iv_load = 1; iv_in = miv; m_iv = miv; end
            else iv_load = 0;
        end
        iv_load = 0;
        total++;
        if (out_valid !== 1'b1) $display("FAIL out_valid_wait: out_valid=%b want 1 within 200 cycles", out_valid);
        else pass_cnt++;
        total++;
        if (starts !== 1) $display("FAIL core_start_count: got %0d want 1", starts);
        else pass_cnt++;
        total++;
        if (bad_rdy !== 0) $display("FAIL in_ready_busy: high on %0d busy cycles want 0", bad_rdy);
        else pass_cnt++;
        total++;
        if (out_data !== exp) $display("FAIL out_data: got %h want %h", out_data, exp);
        else pass_cnt++;
        total++;
        if (out_last !== last) $display("FAIL out_last: got %b want %b", out_last, last);
        else pass_cnt++;
        total++;
        if (blk_count !== exp_cnt) $display("FAIL blk_count: got %0d want %0d", blk_count, exp_cnt);
        else pass_cnt++;
        held = out_data;
        bad_hold = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || core_start !== 1'b0) bad_hold++;
        end
        total++;
        if (bad_hold !== 0) $display("FAIL backpressure_hold: %0d unstable cycles of %0d want 0", bad_hold, hold);
        else pass_cnt++;
        @(negedge clk);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        total++;
        if (out_valid !== 1'b0) $display("FAIL out_handshake: out_valid=%b want 0", out_valid);
        else pass_cnt++;
        m_cnt = exp_cnt;
        m_chain = last ? m_iv : exp;
        last_out = exp;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
        else pass_cnt++;
        total++;
        if ({out_valid, out_last, core_start, err_timeout} !== 4'b0)
            $display("FAIL reset_flags: got %b want 0000", {out_valid, out_last, core_start, err_timeout});
        else pass_cnt++;
        total++;
        if (blk_count !== 16'd0 || out_data !== '0 || core_plaintext !== '0 || core_key !== '0)
            $display("FAIL reset_data: cnt=%0d out=%h pt=%h key=%h want all 0", blk_count, out_data, core_plaintext, core_key);
        else pass_cnt++;
        rst = 0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_fips_block();
        send(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b1,
             '0, 1'b0, '0, 0, 3);
        total++;
        if (last_out !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a)
            $display("FAIL fips_ct: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", last_out);
        else pass_cnt++;
    endtask

    task automatic test_cbc_backpressure();
        send(PT1, K2, 1'b0, 1'b1, IV2, 1'b0, '0, 20, 4);
        total++;
        if (last_out !== CT1) $display("FAIL cbc_ct1: got %h want %h", last_out, CT1);
        else pass_cnt++;
        send(PT2, K2, 1'b1, 1'b0, '0, 1'b0, '0, 0, 2);
        total++;
        if (last_out !== CT2) $display("FAIL cbc_ct2: got %h want %h", last_out, CT2);
        else pass_cnt++;
    endtask

    task automatic test_iv_same_cycle();
        send(rnd128(), rnd128(), 1'b0, 1'b1, rnd128(), 1'b0, '0, 1, 1);
        send(PT1, K2, 1'b1, 1'b1, IV2, 1'b0, '0, 0, 5);
        total++;
        if (last_out !== CT1) $display("FAIL iv_same_cycle_ct1: got %h want %h", last_out, CT1);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            send(rnd128(), rnd128(), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, rnd128(),
                 $urandom_range(0, 5) == 0, rnd128(), $urandom_range(0, 3), $urandom_range(1, 8));
    endtask

    task automatic test_timeout();
        int n, ov;
        stub_en = 0;
        core_lat = 3;
        @(negedge clk);
        in_valid = 1; in_data = rnd128(); key_in = rnd128(); in_last = 0;
        @(posedge clk); #1;
        in_valid = 0;
        n = 0; ov = 0;
        while (err_timeout !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
            if (out_valid === 1'b1) ov++;
        end
        total++;
        if (n !== 66) $display("FAIL timeout_cycles: err seen after %0d negedges want 66", n);
        else pass_cnt++;
        total++;
        if (ov !== 0) $display("FAIL timeout_no_output: out_valid high %0d cycles want 0", ov);
        else pass_cnt++;
        total++;
        if (in_ready !== 1'b1 || blk_count !== 16'd0)
            $display("FAIL timeout_idle: in_ready=%b cnt=%0d want 1/0", in_ready, blk_count);
        else pass_cnt++;
        stub_en = 1;
        m_chain = m_iv;
        m_cnt = 0;
        send(rnd128(), rnd128(), 1'b0, 1'b0, '0, 1'b0, '0, 0, 2);
        total++;
        if (err_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", err_timeout);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_wait();
        int ov, st;
        core_lat = 12;
        @(negedge clk);
        in_valid = 1; in_data = rnd128(); key_in = rnd128(); in_last = 0;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        #1;
        total++;
        if ({in_ready, out_valid, out_last, core_start, err_timeout} !== 5'b0)
            $display("FAIL wait_reset_flags: got %b want 00000", {in_ready, out_valid, out_last, core_start, err_timeout});
        else pass_cnt++;
        total++;
        if (blk_count !== 16'd0 || out_data !== '0 || core_plaintext !== '0 || core_key !== '0)
            $display("FAIL wait_reset_data: cnt=%0d out=%h pt=%h key=%h want all 0", blk_count, out_data, core_plaintext, core_key);
        else pass_cnt++;
        @(negedge clk);
        rst = 0;
        m_iv = '0; m_chain = '0; m_cnt = '0;
        ov = 0; st = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) ov++;
            if (core_start === 1'b1) st++;
        end
        total++;
        if (ov !== 0 || st !== 0) $display("FAIL spurious_done: out_valid=%0d start=%0d cycles want 0/0", ov, st);
        else pass_cnt++;
        send(rnd128(), rnd128(), 1'b1, 1'b0, '0, 1'b0, '0, 1, 3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fips_block();
        test_cbc_backpressure();
        test_iv_same_cycle();
        test_random();
        test_timeout();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
